// File: rtl/lift_pkg.sv
// Shared types and constants for the lifting-wavelet squash sequencer and datapath.
package lift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } lift_state_e;

    localparam int unsigned DEF_ADDR_W   = 6;
    localparam int unsigned DEF_LINE_LEN = 64;
    localparam int unsigned DEF_H_LAT    = 4;
    localparam int unsigned DEF_L_LAT    = 6;

    // H = odd - (even >> H_SHIFT); L = even + (H >> L_SHIFT)
    localparam int unsigned H_SHIFT = 1;
    localparam int unsigned L_SHIFT = 2;

endpackage

// File: rtl/lift_seq_ctrl_if.sv
// Control/status bundle between the line sequencer (master) and frame control plus datapath (slave).
interface lift_seq_ctrl_if
    import lift_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              start;
    logic              out_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic              phase;
    logic              pipe_en;
    logic              h_valid;
    logic              l_valid;
    logic [ADDR_W-2:0] h_idx;
    logic [ADDR_W-2:0] l_idx;
    logic              busy;
    logic              done;

    modport master (
        input  start, out_ready,
        output rom_addr, phase, pipe_en, h_valid, l_valid, h_idx, l_idx, busy, done
    );

    modport slave (
        output start, out_ready,
        input  rom_addr, phase, pipe_en, h_valid, l_valid, h_idx, l_idx, busy, done
    );
endinterface

// File: rtl/lift_valid_pipe.sv
// Enable-gated valid delay line tracking datapath latency; taps give H and L coefficient valid.
module lift_valid_pipe
    import lift_pkg::*;
#(
    parameter int unsigned H_LAT = DEF_H_LAT,
    parameter int unsigned L_LAT = DEF_L_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_bit,
    output logic o_h_valid,
    output logic o_l_valid
);
    logic [L_LAT-1:0] r_sr;

    // Stage k (1-based) holds the issue bit after k enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr <= {r_sr[L_LAT-2:0], i_bit};
        end
    end

    assign o_h_valid = r_sr[H_LAT-1];
    assign o_l_valid = r_sr[L_LAT-1];

endmodule

// File: rtl/lift_seq_ctrl.sv
// Line sequencer for the lifting-wavelet datapath: ROM addressing, back-pressure gating,
// coefficient valid/index tracking and busy/done handshake.
module lift_seq_ctrl
    import lift_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned LINE_LEN = DEF_LINE_LEN,
    parameter int unsigned H_LAT    = DEF_H_LAT,
    parameter int unsigned L_LAT    = DEF_L_LAT
) (
    input  logic            clk,
    input  logic            rst,
    lift_seq_ctrl_if.master bus
);
    localparam int unsigned       IDX_W     = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_LEN / 2 - 1);

    lift_state_e       r_state;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [IDX_W-1:0]  r_h_idx;
    logic [IDX_W-1:0]  r_l_idx;

    logic w_busy;
    logic w_pipe_en;
    logic w_issue;
    logic w_h_valid;
    logic w_l_valid;
    logic w_h_xfer;
    logic w_l_xfer;

    assign w_busy    = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign w_pipe_en = w_busy & bus.out_ready;
    assign w_issue   = (r_state == ST_FETCH) & r_rom_addr[0] & w_pipe_en;
    assign w_h_xfer  = w_h_valid & w_pipe_en;
    assign w_l_xfer  = w_l_valid & w_pipe_en;

    lift_valid_pipe #(
        .H_LAT (H_LAT),
        .L_LAT (L_LAT)
    ) u_valid_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_pipe_en),
        .i_bit     (w_issue),
        .o_h_valid (w_h_valid),
        .o_l_valid (w_l_valid)
    );

    // Line FSM and ROM address; everything holds while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rom_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rom_addr <= '0;
                    if (bus.start) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_pipe_en) begin
                        if (r_rom_addr == LAST_ADDR) begin
                            r_state    <= ST_DRAIN;
                            r_rom_addr <= '0;
                        end else begin
                            r_rom_addr <= r_rom_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_l_xfer && (r_l_idx == LAST_IDX)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_rom_addr <= '0;
                end
            endcase
        end
    end

    // Coefficient indices advance per transfer and wrap at the half-line boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_idx <= '0;
            r_l_idx <= '0;
        end else begin
            if (w_h_xfer) begin
                r_h_idx <= (r_h_idx == LAST_IDX) ? '0 : r_h_idx + IDX_W'(1);
            end
            if (w_l_xfer) begin
                r_l_idx <= (r_l_idx == LAST_IDX) ? '0 : r_l_idx + IDX_W'(1);
            end
        end
    end

    assign bus.rom_addr = r_rom_addr;
    assign bus.phase    = r_rom_addr[0];
    assign bus.pipe_en  = w_pipe_en;
    assign bus.h_valid  = w_h_valid;
    assign bus.l_valid  = w_l_valid;
    assign bus.h_idx    = r_h_idx;
    assign bus.l_idx    = r_l_idx;
    assign bus.busy     = w_busy;
    assign bus.done     = (r_state == ST_DONE);

endmodule

// File: doc/lift_seq_ctrl.md
Name: lift_seq_ctrl

Overview:
Sequencer for the 1-D lifting-wavelet squash datapath (even/odd split, high-pass H = odd - even/2, low-pass L = even + H/4). It drives the sample ROM address and even/odd phase for one line of LINE_LEN samples. It gates the datapath pipeline registers against downstream back-pressure and tracks pipeline latency, flagging when each H and L coefficient is valid. It signals busy/done to the frame-level control.

Parameters:
ADDR_W, 6, sample ROM address width
LINE_LEN, 64, samples per line; must be even and no greater than 2**ADDR_W
H_LAT, 4, cycles from odd-sample address issue to H coefficient valid at datapath output
L_LAT, 6, cycles from odd-sample address issue to L coefficient valid; legal range H_LAT < L_LAT <= 15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin one line; accepted only in IDLE
out_ready  in  1  downstream can accept coefficients this cycle
rom_addr  out  ADDR_W  sample ROM address
phase  out  1  0 = even sample, 1 = odd sample (equals rom_addr[0])
pipe_en  out  1  clock enable for all datapath pipeline registers
h_valid  out  1  H coefficient valid at datapath output
l_valid  out  1  L coefficient valid at datapath output
h_idx  out  ADDR_W-1  index of the current H coefficient
l_idx  out  ADDR_W-1  index of the current L coefficient
busy  out  1  high in FETCH and DRAIN
done  out  1  one-cycle pulse at end of line

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; it immediately clears all state and outputs to 0, state = IDLE.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: all outputs 0. start=1 moves to FETCH on the next edge, with rom_addr=0.
- pipe_en = busy & out_ready. When pipe_en=0, rom_addr, the valid delay line, h_idx, l_idx and state all hold. h_valid/l_valid hold their level. A coefficient transfers only on a cycle with valid & out_ready.
- FETCH: rom_addr increments on each pipe_en cycle. After the cycle that issues LINE_LEN-1 with pipe_en=1, the state moves to DRAIN and rom_addr returns to 0.
- Issue bit: an issue bit = (FETCH & phase & pipe_en) enters the valid delay line, depth L_LAT. h_valid = tap H_LAT; l_valid = tap L_LAT.
- Coefficient indices: h_idx and l_idx increment after each transferred coefficient and wrap to 0 after LINE_LEN/2-1.
- DRAIN: leaves when the last L (l_idx = LINE_LEN/2-1) transfers, moving to DONE.
- DONE: lasts one cycle with done=1 and busy=0, then IDLE.
- start outside IDLE is ignored, including start in the DONE cycle.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package lift_pkg holds:
  - state enum (IDLE, FETCH, DRAIN, DONE)
  - default LINE_LEN, H_LAT, L_LAT
  - the H shift (1) and L shift (2) constants, shared with the datapath
- One sub-module, lift_valid_pipe: an enable-gated shift register of depth L_LAT with H_LAT/L_LAT taps and asynchronous clear.

Test Plan:
1. Assert rst mid-cycle -> all outputs 0 asynchronously; state IDLE.
2. Defaults, start pulsed at cycle 0, out_ready=1:
   - rom_addr 0..63 on cycles 1..64
   - h_valid on cycles 6,8,...,68; l_valid on cycles 8,...,70
   - h_idx 0..31 and l_idx 0..31
   - done=1 on cycle 71 only; busy=0 from cycle 71
3. out_ready=0 for 3 cycles while rom_addr=10 -> rom_addr holds 10, pipe_en=0, valid levels hold; done moves to cycle 74.
4. start pulsed during FETCH and again in the DONE cycle -> no restart; exactly 32 H and 32 L transfers, one done pulse.
5. rst asserted in FETCH at rom_addr=20, released, then start -> fresh line from rom_addr=0, full 32+32 coefficients, indices from 0.
6. out_ready toggling every cycle through DRAIN -> each h_idx/l_idx value appears exactly once per transfer, none lost or duplicated; done after l_idx 31 transfers.
